muldiv_seq: RTL

// - Iterative MIPS HI/LO multiply/divide sequencer for MULT/MULTU/DIV/DIVU.
// - Borrows the shared 32-bit EX-stage ALU for every add/sub/negate step.
// - EX stalls the pipeline and hands the ALU to this block while alu_req=1.
// - Results go to architectural hi/lo for MFHI/MFLO.

---
 rtl/muldiv_pkg.sv | 28 ++
 rtl/muldiv_iter_step.sv | 51 +++++
 rtl/muldiv_seq.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and ALU function codes for the iterative HI/LO multiply/divide sequencer.
package muldiv_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_NEGA,
    ST_NEGB,
    ST_ITER,
    ST_FIXLO,
    ST_FIXHI,
    ST_DONE
  } md_state_e;

  // F[3] inverts operand B and supplies carry-in 1; F[2:0] selects AND/OR/ADD.
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b1010;
  localparam logic [3:0] ALU_ORN = 4'b1001;

endpackage

// File: rtl/muldiv_iter_step.sv
// One shift-add multiply or restoring-divide iteration: ALU operand selection and next accumulator values.
module muldiv_iter_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] acc_hi,
  input  logic [WIDTH-1:0] acc_lo,
  input  logic [WIDTH-1:0] opnd,
  input  logic [WIDTH-1:0] alu_y,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_f,
  output logic [WIDTH-1:0] hi_nxt,
  output logic [WIDTH-1:0] lo_nxt
);

  logic [WIDTH-1:0] rem_sh;
  logic             take;
  logic             carry;

  // The shifted-out remainder msb means r' exceeds 2^W, so the subtract always succeeds.
  assign rem_sh = {acc_hi[WIDTH-2:0], acc_lo[WIDTH-1]};
  assign take   = acc_hi[WIDTH-1] | (rem_sh >= opnd);
  assign carry  = (alu_y < acc_hi);

  // Operand selection and result update are kept apart so the external ALU path stays acyclic.
  always_comb begin
    if (is_div) begin
      alu_a = rem_sh;
      alu_b = opnd;
      alu_f = ALU_SUB;
    end else begin
      alu_a = acc_hi;
      alu_b = acc_lo[0] ? opnd : '0;
      alu_f = ALU_ADD;
    end
  end

  always_comb begin
    if (is_div) begin
      hi_nxt = take ? alu_y : rem_sh;
      lo_nxt = {acc_lo[WIDTH-2:0], take};
    end else begin
      hi_nxt = {carry, alu_y[WIDTH-1:1]};
      lo_nxt = {alu_y[0], acc_lo[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative MIPS MULT/MULTU/DIV/DIVU sequencer that borrows the EX-stage ALU; signed support
// (sign-magnitude pre/post fix-up states) is built only when MULDIV_SIGNED_EN is defined.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             alu_req,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_f,
  input  logic [WIDTH-1:0] alu_y
);

  localparam int CW = $clog2(WIDTH) + 1;

  md_state_e        state, state_nxt;
  md_op_e           op_e;
  logic [CW-1:0]    count, count_nxt;
  logic [WIDTH-1:0] acc_hi, acc_hi_nxt;
  logic [WIDTH-1:0] acc_lo, acc_lo_nxt;
  logic [WIDTH-1:0] opnd, opnd_nxt;
  logic             is_div, is_div_nxt;
  logic             op_div;
  logic [WIDTH-1:0] step_a, step_b, step_hi, step_lo;
  logic [3:0]       step_f;
`ifdef MULDIV_SIGNED_EN
  logic             is_signed, is_signed_nxt;
  logic             rneg, rneg_nxt;
  logic             qneg, qneg_nxt;
  logic             op_signed;

  assign op_signed = (op_e == MD_MULT) || (op_e == MD_DIV);
`endif

  assign op_e   = md_op_e'(op);
  assign op_div = (op_e == MD_DIV) || (op_e == MD_DIVU);
  assign busy   = (state != ST_IDLE);
  assign done   = (state == ST_DONE);

  muldiv_iter_step #(.WIDTH(WIDTH)) u_step (
    .is_div (is_div),
    .acc_hi (acc_hi),
    .acc_lo (acc_lo),
    .opnd   (opnd),
    .alu_y  (alu_y),
    .alu_a  (step_a),
    .alu_b  (step_b),
    .alu_f  (step_f),
    .hi_nxt (step_hi),
    .lo_nxt (step_lo)
  );

  // NOTE: every output gets a default before the case so no path leaves a latch behind.
  always_comb begin
    alu_req = 1'b0;
    alu_a   = '0;
    alu_b   = '0;
    alu_f   = ALU_AND;
    case (state)
      ST_ITER: begin
        alu_req = 1'b1;
        alu_a   = step_a;
        alu_b   = step_b;
        alu_f   = step_f;
      end
`ifdef MULDIV_SIGNED_EN
      ST_NEGA: begin
        alu_req = 1'b1;
        alu_b   = acc_lo;
        alu_f   = ALU_SUB;
      end
      ST_NEGB: begin
        alu_req = 1'b1;
        alu_b   = opnd;
        alu_f   = ALU_SUB;
      end
      ST_FIXLO: begin
        alu_req = 1'b1;
        alu_b   = acc_lo;
        alu_f   = ALU_SUB;
      end
      ST_FIXHI: begin
        // A borrow only propagates into HI when the negated LO is zero; otherwise HI is just inverted.
        alu_req = 1'b1;
        alu_b   = acc_hi;
        alu_f   = (!is_div && acc_lo != '0) ? ALU_ORN : ALU_SUB;
      end
`endif
      default: ;
    endcase
  end

  always_comb begin
    state_nxt  = state;
    count_nxt  = count;
    acc_hi_nxt = acc_hi;
    acc_lo_nxt = acc_lo;
    opnd_nxt   = opnd;
    is_div_nxt = is_div;
`ifdef MULDIV_SIGNED_EN
    is_signed_nxt = is_signed;
    rneg_nxt      = rneg;
    qneg_nxt      = qneg;
`endif
    case (state)
      ST_IDLE: begin
        if (start && !flush) begin
          is_div_nxt = op_div;
          acc_hi_nxt = '0;
          acc_lo_nxt = a;
          opnd_nxt   = b;
          count_nxt  = CW'(WIDTH);
`ifdef MULDIV_SIGNED_EN
          is_signed_nxt = op_signed;
          rneg_nxt      = op_div ? a[WIDTH-1] : (a[WIDTH-1] ^ b[WIDTH-1]);
          qneg_nxt      = a[WIDTH-1] ^ b[WIDTH-1];
`endif
          if (op_div && b == '0) begin
            state_nxt  = ST_DONE;
            acc_hi_nxt = a;
            acc_lo_nxt = '1;
          end
`ifdef MULDIV_SIGNED_EN
          else if (op_signed) state_nxt = ST_NEGA;
`endif
          else state_nxt = ST_ITER;
        end
      end
      ST_ITER: begin
        acc_hi_nxt = step_hi;
        acc_lo_nxt = step_lo;
        count_nxt  = count - CW'(1);
        if (count == CW'(1)) begin
`ifdef MULDIV_SIGNED_EN
          state_nxt = is_signed ? ST_FIXLO : ST_DONE;
`else
          state_nxt = ST_DONE;
`endif
        end
      end
`ifdef MULDIV_SIGNED_EN
      ST_NEGA: begin
        if (acc_lo[WIDTH-1]) acc_lo_nxt = alu_y;
        state_nxt = ST_NEGB;
      end
      ST_NEGB: begin
        if (opnd[WIDTH-1]) opnd_nxt = alu_y;
        state_nxt = ST_ITER;
      end
      ST_FIXLO: begin
        if (is_div ? qneg : rneg) acc_lo_nxt = alu_y;
        state_nxt = ST_FIXHI;
      end
      ST_FIXHI: begin
        if (rneg) acc_hi_nxt = alu_y;
        state_nxt = ST_DONE;
      end
`endif
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    if (flush && state != ST_IDLE) state_nxt = ST_IDLE;
  end

  // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      count  <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      opnd   <= '0;
      is_div <= 1'b0;
      hi     <= '0;
      lo     <= '0;
`ifdef MULDIV_SIGNED_EN
      is_signed <= 1'b0;
      rneg      <= 1'b0;
      qneg      <= 1'b0;
`endif
    end else begin
      state  <= state_nxt;
      count  <= count_nxt;
      acc_hi <= acc_hi_nxt;
      acc_lo <= acc_lo_nxt;
      opnd   <= opnd_nxt;
      is_div <= is_div_nxt;
`ifdef MULDIV_SIGNED_EN
      is_signed <= is_signed_nxt;
      rneg      <= rneg_nxt;
      qneg      <= qneg_nxt;
`endif
      if (state_nxt == ST_DONE) begin
        hi <= acc_hi_nxt;
        lo <= acc_lo_nxt;
      end
    end
  end

endmodule
